// File: rtl/regfile_pkg.sv
// Shared helpers for the register file: byte-lane merging and packed-port slicing.
package regfile_pkg;

    // Widest register supported by be_merge; callers zero-extend into it and truncate back.
    localparam int unsigned MAX_WIDTH = 512;
    localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

    // Replace each byte of old_val whose enable bit is set with the matching byte of new_val.
    function automatic logic [MAX_WIDTH-1:0] be_merge(
        input logic [MAX_WIDTH-1:0] old_val,
        input logic [MAX_WIDTH-1:0] new_val,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_val;
        for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Bit offset of port `port` inside a packed array of `width`-bit fields.
    function automatic int unsigned addr_slice(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

    // An address holds state only if it is in range and is not the hardwired zero register.
    function automatic logic addr_valid(input int unsigned addr, input int unsigned length,
                                        input logic zero_reg);
        return (addr < length) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, writebacks clear it, busy_cnt tracks the population.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned LENGTH     = 4,
    parameter int unsigned ZERO_REG   = 0,
    localparam int unsigned ADDR_WIDTH = $clog2(LENGTH),
    localparam int unsigned CNT_WIDTH  = $clog2(LENGTH + 1),
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DEPTH-1:0]      busy,
    output logic [CNT_WIDTH-1:0]  busy_cnt,
    output logic                  conflict
);

    logic [DEPTH-1:0] valid_mask;
    logic [DEPTH-1:0] busy_nxt;
    logic             set_ok;
    logic             clr_ok;
    logic             inc;
    logic             dec;

    // Addresses that may ever hold a busy bit.
    always_comb begin
        valid_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_mask[i] = addr_valid(i, LENGTH, ZERO_REG != 0);
        end
    end

    // Conflict, next busy vector and population delta; the clear applies before the set.
    always_comb begin
        conflict = set_en & busy[set_addr] & ~(clr_en & (clr_addr == set_addr));
        clr_ok   = clr_en & valid_mask[clr_addr];
        set_ok   = set_en & valid_mask[set_addr] & ~conflict;
        busy_nxt = busy;
        if (clr_ok) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[set_addr] = 1'b1;
        end
        // A same-address clear+set counts as -1 then +1, so the count is unchanged.
        dec = clr_ok & busy[clr_addr];
        inc = set_ok & ~(busy[set_addr] & ~(clr_ok & (clr_addr == set_addr)));
    end

    // Busy state and counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + CNT_WIDTH'(inc) - CNT_WIDTH'(dec);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with byte-enable writes, write-to-read forwarding and a busy scoreboard.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LENGTH     = 4,
    parameter int unsigned RD_PORTS   = 2,
    parameter int unsigned ZERO_REG   = 0,
    localparam int unsigned ADDR_WIDTH = $clog2(LENGTH),
    localparam int unsigned BYTES      = WIDTH / 8,
    localparam int unsigned CNT_WIDTH  = $clog2(LENGTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]    rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [BYTES-1:0]             wr_be,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    output logic                         rsv_conflict,
    output logic [CNT_WIDTH-1:0]         busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_mask;
    logic [DEPTH-1:0] busy;
    logic [WIDTH-1:0] wr_merged;

    // Addresses backed by real storage.
    always_comb begin
        valid_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_mask[i] = addr_valid(i, LENGTH, ZERO_REG != 0);
        end
    end

    // Merged write value, shared by the storage update and the forwarding path.
    always_comb begin
        wr_merged = WIDTH'(be_merge(MAX_WIDTH'(mem[wr_addr]), MAX_WIDTH'(wr_data),
                                    MAX_BYTES'(wr_be)));
    end

    // Storage update; out-of-range and zero-register writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && valid_mask[wr_addr]) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // Combinational read ports with same-cycle write forwarding.
    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            a = rd_addr[addr_slice(p, ADDR_WIDTH) +: ADDR_WIDTH];
            if (valid_mask[a]) begin
                if (wr_en && (wr_addr == a)) begin
                    rd_data[addr_slice(p, WIDTH) +: WIDTH] = wr_merged;
                    rd_busy[p] = 1'b0;
                end else begin
                    rd_data[addr_slice(p, WIDTH) +: WIDTH] = mem[a];
                    rd_busy[p] = busy[a];
                end
            end
        end
    end

    reg_scoreboard #(
        .LENGTH   (LENGTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rsv_en),
        .set_addr (rsv_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt),
        .conflict (rsv_conflict)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: default, 16-bit and zero-register/odd-length instances.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: WIDTH=8, LENGTH=4, RD_PORTS=2, ZERO_REG=0
    logic        rst_a;
    logic [3:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic        wr_en_a;
    logic [1:0]  wr_addr_a;
    logic [7:0]  wr_data_a;
    logic [0:0]  wr_be_a;
    logic        rsv_en_a;
    logic [1:0]  rsv_addr_a;
    logic        rsv_conflict_a;
    logic [2:0]  busy_cnt_a;

    // Instance B: WIDTH=16, LENGTH=4
    logic        rst_b;
    logic [3:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic [1:0]  rd_busy_b;
    logic        wr_en_b;
    logic [1:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic [1:0]  wr_be_b;
    logic        rsv_en_b;
    logic [1:0]  rsv_addr_b;
    logic        rsv_conflict_b;
    logic [2:0]  busy_cnt_b;

    // Instance Z: WIDTH=8, LENGTH=3, ZERO_REG=1
    logic        rst_z;
    logic [3:0]  rd_addr_z;
    logic [15:0] rd_data_z;
    logic [1:0]  rd_busy_z;
    logic        wr_en_z;
    logic [1:0]  wr_addr_z;
    logic [7:0]  wr_data_z;
    logic [0:0]  wr_be_z;
    logic        rsv_en_z;
    logic [1:0]  rsv_addr_z;
    logic        rsv_conflict_z;
    logic [1:0]  busy_cnt_z;

    reg_file_sb #(.WIDTH(8), .LENGTH(4), .RD_PORTS(2), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst(rst_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_be(wr_be_a),
        .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a), .rsv_conflict(rsv_conflict_a),
        .busy_cnt(busy_cnt_a)
    );

    reg_file_sb #(.WIDTH(16), .LENGTH(4), .RD_PORTS(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_be(wr_be_b),
        .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b), .rsv_conflict(rsv_conflict_b),
        .busy_cnt(busy_cnt_b)
    );

    reg_file_sb #(.WIDTH(8), .LENGTH(3), .RD_PORTS(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst_z), .rd_addr(rd_addr_z), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .wr_en(wr_en_z), .wr_addr(wr_addr_z), .wr_data(wr_data_z), .wr_be(wr_be_z),
        .rsv_en(rsv_en_z), .rsv_addr(rsv_addr_z), .rsv_conflict(rsv_conflict_z),
        .busy_cnt(busy_cnt_z)
    );

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_addr;
        logic [7:0] wr_data;
        logic       wr_be;
        logic       rsv_en;
        logic [1:0] rsv_addr;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] busy;      // {port1, port0}
        logic       conflict;
        logic [2:0] cnt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] busy;
        logic       conflict;
        logic [2:0] cnt;
    } exp_t;

    vec_t tbl[16];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                                input logic be, input logic re, input logic [1:0] rsa,
                                input logic [1:0] ra0, input logic [1:0] ra1,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] busy, input logic cf, input logic [2:0] cnt);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
        v.rsv_en = re; v.rsv_addr = rsa; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.busy = busy; v.conflict = cf; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle_all();
        wr_en_a = 0; rsv_en_a = 0; wr_en_b = 0; rsv_en_b = 0; wr_en_z = 0; rsv_en_z = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_a = 1; rst_b = 1; rst_z = 1;
        rd_addr_a = '0; wr_addr_a = '0; wr_data_a = '0; wr_be_a = '0; rsv_addr_a = '0;
        rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0; wr_be_b = '0; rsv_addr_b = '0;
        rd_addr_z = '0; wr_addr_z = '0; wr_data_z = '0; wr_be_z = '0; rsv_addr_z = '0;
        idle_all();

        tbl[0]  = mk(1, 1, 8'hBB, 1, 0, 0, 1, 2, 8'hBB, 8'h00, 2'b00, 0, 0);
        tbl[1]  = mk(1, 2, 8'hCC, 1, 0, 0, 1, 2, 8'hBB, 8'hCC, 2'b00, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0, 0, 0, 1, 2, 8'hBB, 8'hCC, 2'b00, 0, 0);
        tbl[3]  = mk(1, 3, 8'hDD, 1, 0, 0, 3, 0, 8'hDD, 8'h00, 2'b00, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 0, 0, 0, 3, 3, 8'hDD, 8'hDD, 2'b00, 0, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0, 1, 1, 1, 1, 8'hBB, 8'hBB, 2'b00, 0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0, 1, 1, 1, 2, 8'hBB, 8'hCC, 2'b01, 1, 1);
        tbl[7]  = mk(1, 1, 8'h55, 1, 1, 2, 1, 2, 8'h55, 8'hCC, 2'b00, 0, 1);
        tbl[8]  = mk(0, 0, 8'h00, 0, 0, 0, 1, 2, 8'h55, 8'hCC, 2'b10, 0, 1);
        tbl[9]  = mk(1, 2, 8'h77, 1, 1, 2, 2, 1, 8'h77, 8'h55, 2'b00, 0, 1);
        tbl[10] = mk(0, 0, 8'h00, 0, 0, 0, 2, 1, 8'h77, 8'h55, 2'b01, 0, 1);
        tbl[11] = mk(1, 2, 8'hFF, 0, 0, 0, 2, 2, 8'h77, 8'h77, 2'b00, 0, 1);
        tbl[12] = mk(0, 0, 8'h00, 0, 0, 0, 2, 0, 8'h77, 8'h00, 2'b00, 0, 0);
        tbl[13] = mk(1, 3, 8'h01, 1, 1, 0, 0, 3, 8'h00, 8'h01, 2'b00, 0, 0);
        tbl[14] = mk(0, 0, 8'h00, 0, 1, 3, 0, 3, 8'h00, 8'h01, 2'b01, 0, 1);
        tbl[15] = mk(0, 0, 8'h00, 0, 0, 0, 0, 3, 8'h00, 8'h01, 2'b11, 0, 2);

        // Reset state: rst held after its first edge; every address reads zero, never conflicts.
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            rd_addr_a = {a[1:0], a[1:0]};
            rsv_en_a = 1; rsv_addr_a = a[1:0];
            #1;
            chk($sformatf("rst_data_r%0d", a), {16'h0, rd_data_a}, 32'h0);
            chk($sformatf("rst_busy_r%0d", a), {30'h0, rd_busy_a}, 32'h0);
            chk($sformatf("rst_conflict_r%0d", a), {31'h0, rsv_conflict_a}, 32'h0);
        end
        chk("rst_cnt", {29'h0, busy_cnt_a}, 32'h0);
        rsv_en_a = 0;
        @(negedge clk);
        rst_a = 0; rst_b = 0; rst_z = 0;

        // Table-driven vectors on instance A through the scoreboard queue.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en_a = tbl[i].wr_en; wr_addr_a = tbl[i].wr_addr;
            wr_data_a = tbl[i].wr_data; wr_be_a = tbl[i].wr_be;
            rsv_en_a = tbl[i].rsv_en; rsv_addr_a = tbl[i].rsv_addr;
            rd_addr_a = {tbl[i].ra1, tbl[i].ra0};
            e.idx = i; e.d0 = tbl[i].d0; e.d1 = tbl[i].d1; e.busy = tbl[i].busy;
            e.conflict = tbl[i].conflict; e.cnt = tbl[i].cnt;
            exp_q.push_back(e);
            #2;
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'h0, 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d_d0", e.idx), {24'h0, rd_data_a[7:0]}, {24'h0, e.d0});
                chk($sformatf("v%0d_d1", e.idx), {24'h0, rd_data_a[15:8]}, {24'h0, e.d1});
                chk($sformatf("v%0d_busy", e.idx), {30'h0, rd_busy_a}, {30'h0, e.busy});
                chk($sformatf("v%0d_conflict", e.idx), {31'h0, rsv_conflict_a}, {31'h0, e.conflict});
                chk($sformatf("v%0d_cnt", e.idx), {29'h0, busy_cnt_a}, {29'h0, e.cnt});
            end
        end

        // Reset with r0/r3 busy; the write and reservation in the reset cycle are ignored.
        @(negedge clk);
        rst_a = 1; wr_en_a = 1; wr_addr_a = 1; wr_data_a = 8'hEE; wr_be_a = 1;
        rsv_en_a = 1; rsv_addr_a = 1;
        @(negedge clk);
        rst_a = 0; idle_all(); rd_addr_a = {2'd3, 2'd1};
        #2;
        chk("midrst_data", {16'h0, rd_data_a}, 32'h0);
        chk("midrst_busy", {30'h0, rd_busy_a}, 32'h0);
        chk("midrst_cnt", {29'h0, busy_cnt_a}, 32'h0);
        rd_addr_a = {2'd2, 2'd0};
        #1;
        chk("midrst_busy_r0", {30'h0, rd_busy_a}, 32'h0);

        // Byte enables on the 16-bit instance.
        @(negedge clk);
        wr_en_b = 1; wr_addr_b = 2; wr_data_b = 16'h1234; wr_be_b = 2'b11; rd_addr_b = {2'd1, 2'd2};
        #2 chk("be_full_fwd", {16'h0, rd_data_b[15:0]}, 32'h1234);
        @(negedge clk);
        wr_data_b = 16'hABCD; wr_be_b = 2'b10;
        #2 chk("be_hi_fwd", rd_data_b, 32'h0000AB34);
        @(negedge clk);
        wr_en_b = 0;
        #2 chk("be_hi_stored", rd_data_b, 32'h0000AB34);
        chk("be_hi_busy", {30'h0, rd_busy_b}, 32'h0);
        @(negedge clk);
        wr_en_b = 1; wr_data_b = 16'h00EF; wr_be_b = 2'b01;
        #2 chk("be_lo_fwd", {16'h0, rd_data_b[15:0]}, 32'hABEF);
        @(negedge clk);
        wr_en_b = 0;
        #2 chk("be_lo_stored", {16'h0, rd_data_b[15:0]}, 32'hABEF);

        // Zero register and out-of-range address on the LENGTH=3 instance.
        @(negedge clk);
        wr_en_z = 1; wr_addr_z = 0; wr_data_z = 8'hFF; wr_be_z = 1;
        rsv_en_z = 1; rsv_addr_z = 0; rd_addr_z = {2'd0, 2'd0};
        #2;
        chk("z0_fwd_data", {16'h0, rd_data_z}, 32'h0);
        chk("z0_fwd_busy", {30'h0, rd_busy_z}, 32'h0);
        chk("z0_conflict", {31'h0, rsv_conflict_z}, 32'h0);
        @(negedge clk);
        wr_en_z = 0; rsv_en_z = 1; rsv_addr_z = 0; rd_addr_z = {2'd1, 2'd0};
        #2;
        chk("z0_data", {16'h0, rd_data_z}, 32'h0);
        chk("z0_busy", {30'h0, rd_busy_z}, 32'h0);
        chk("z0_conflict2", {31'h0, rsv_conflict_z}, 32'h0);
        chk("z0_cnt", {30'h0, busy_cnt_z}, 32'h0);
        @(negedge clk);
        rsv_addr_z = 1;
        @(negedge clk);
        rsv_addr_z = 2;
        @(negedge clk);
        rsv_en_z = 0; rd_addr_z = {2'd2, 2'd1};
        #2;
        chk("z12_busy", {30'h0, rd_busy_z}, 32'h3);
        chk("z12_cnt", {30'h0, busy_cnt_z}, 32'h2);
        @(negedge clk);
        wr_en_z = 1; wr_addr_z = 3; wr_data_z = 8'h5A; rsv_en_z = 1; rsv_addr_z = 3;
        rd_addr_z = {2'd0, 2'd3};
        #2;
        chk("oor_fwd_data", {16'h0, rd_data_z}, 32'h0);
        chk("oor_busy", {30'h0, rd_busy_z}, 32'h0);
        chk("oor_conflict", {31'h0, rsv_conflict_z}, 32'h0);
        @(negedge clk);
        idle_all(); rd_addr_z = {2'd3, 2'd3};
        #2;
        chk("oor_data", {16'h0, rd_data_z}, 32'h0);
        chk("oor_cnt", {30'h0, busy_cnt_z}, 32'h2);
        @(negedge clk);
        rst_z = 1;
        @(negedge clk);
        rst_z = 0; rd_addr_z = {2'd2, 2'd1};
        #2;
        chk("zrst_cnt", {30'h0, busy_cnt_z}, 32'h0);
        chk("zrst_busy", {30'h0, rd_busy_z}, 32'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
